// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the pipelined Y86-64 core: register index type,
// the "no register" index, the stack-pointer index and the instruction code
// enumeration used by fetch/decode.
// ---------------------------------------------------------------------------
package y86_pkg;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t RNONE = 4'hF;   // "no register" selector
    localparam reg_idx_t RSP   = 4'd4;   // %rsp

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// ---------------------------------------------------------------------------
// pend_counter
// Saturating up/down count of in-flight writers for one architectural
// register. Each cycle the count moves by (#inc bits) - (#dec bits).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          squash: count goes to 0, no error reported
//   inc_i[1:0]     one bit per issuing port (E, M) targeting this register
//   dec_i[1:0]     one bit per retiring port (E, M) writing this register
//   busy_o         a writer stays outstanding after this cycle's retires
//   err_o          this cycle's update over- or underflows (combinational)
// ---------------------------------------------------------------------------
module pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic [1:0] inc_i,
    input  logic [1:0] dec_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int CNT_MAX = (1 << PEND_W) - 1;

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    int                dec_n_s;
    int                sum_s;

    // Next count with saturation at both ends; arithmetic done in int so the
    // intermediate value can go negative or exceed the counter range.
    always_comb begin
        dec_n_s = int'(dec_i[0]) + int'(dec_i[1]);
        sum_s   = int'(cnt_q) + int'(inc_i[0]) + int'(inc_i[1]) - dec_n_s;
        if (clr_i) begin
            cnt_d = '0;
            err_o = 1'b0;
        end else if (sum_s > CNT_MAX) begin
            cnt_d = PEND_W'(CNT_MAX);
            err_o = 1'b1;
        end else if (sum_s < 0) begin
            cnt_d = '0;
            err_o = 1'b1;
        end else begin
            cnt_d = PEND_W'(sum_s);
            err_o = 1'b0;
        end
        // Same-cycle issue is deliberately excluded: a writer retiring now is
        // served by the read bypass, so only the remainder is a hazard.
        busy_o = (int'(cnt_q) - dec_n_s) > 0;
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Y86-64 register file with two combinational read ports (with same-cycle
// write bypass), two synchronous write ports (E, then M; M wins on a tie)
// and a per-register pending-writer scoreboard that flags load/use hazards.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   srcA/srcB -> valA/valB      combinational reads, 0 for RNONE/out of range
//   dstE/valE, dstM/valM        writeback ports, RNONE = no write
//   issue_valid, issue_dstE/M   destinations of the instruction leaving decode
//   flush                       squash every pending count
//   hazard                      a source still has an unretired writer
//   err                         sticky scoreboard over/underflow
//   dbg_sel -> dbg_val          registered debug read (value after writes)
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int NREGS   = 15,
    parameter int RIDX_W  = 4,
    parameter int SP_IDX  = int'(RSP),
    parameter int SP_INIT = 256,
    parameter int PEND_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] srcA,
    input  logic [RIDX_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [RIDX_W-1:0] dstE,
    input  logic [RIDX_W-1:0] dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              issue_valid,
    input  logic [RIDX_W-1:0] issue_dstE,
    input  logic [RIDX_W-1:0] issue_dstM,
    input  logic              flush,
    output logic              hazard,
    output logic              err,
    input  logic [RIDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);

    localparam logic [RIDX_W-1:0] NO_REG = RIDX_W'(RNONE);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [NREGS-1:0]  hit_a_s;
    logic [NREGS-1:0]  hit_b_s;
    logic [NREGS-1:0]  hit_e_s;
    logic [NREGS-1:0]  hit_m_s;
    logic [NREGS-1:0]  hit_ie_s;
    logic [NREGS-1:0]  hit_im_s;
    logic [NREGS-1:0]  hit_dbg_s;

    logic [NREGS-1:0]  busy_s;
    logic [NREGS-1:0]  cnt_err_s;

    logic              err_q;
    logic              err_d;
    logic [DATA_W-1:0] dbg_val_q;
    logic [DATA_W-1:0] dbg_val_d;

    // One-hot register selects per index port. RNONE and indices beyond the
    // array select nothing, which makes reads return 0 and writes no-ops.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            hit_a_s[r]   = (srcA       == RIDX_W'(r)) && (srcA       != NO_REG);
            hit_b_s[r]   = (srcB       == RIDX_W'(r)) && (srcB       != NO_REG);
            hit_e_s[r]   = (dstE       == RIDX_W'(r)) && (dstE       != NO_REG);
            hit_m_s[r]   = (dstM       == RIDX_W'(r)) && (dstM       != NO_REG);
            hit_ie_s[r]  = (issue_dstE == RIDX_W'(r)) && (issue_dstE != NO_REG);
            hit_im_s[r]  = (issue_dstM == RIDX_W'(r)) && (issue_dstM != NO_REG);
            hit_dbg_s[r] = (dbg_sel    == RIDX_W'(r)) && (dbg_sel    != NO_REG);
        end
    end

    // Post-write register image: M has priority over E (popq %rsp rule).
    // Reads and the debug port index this image, which gives the bypass.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            if (hit_m_s[r]) begin
                regs_d[r] = valM;
            end else if (hit_e_s[r]) begin
                regs_d[r] = valE;
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
    end

    // AND-OR read muxes; at most one select bit is set per port.
    always_comb begin
        valA      = '0;
        valB      = '0;
        dbg_val_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            valA      = valA      | ({DATA_W{hit_a_s[r]}}   & regs_d[r]);
            valB      = valB      | ({DATA_W{hit_b_s[r]}}   & regs_d[r]);
            dbg_val_d = dbg_val_d | ({DATA_W{hit_dbg_s[r]}} & regs_d[r]);
        end
    end

    // Pending-writer counters, one per architectural register.
    for (genvar g = 0; g < NREGS; g++) begin : g_pend
        pend_counter #(
            .PEND_W (PEND_W)
        ) u_pend (
            .clk_i  (clk),
            .rst_i  (rst),
            .clr_i  (flush),
            .inc_i  ({issue_valid & hit_im_s[g], issue_valid & hit_ie_s[g]}),
            .dec_i  ({hit_m_s[g], hit_e_s[g]}),
            .busy_o (busy_s[g]),
            .err_o  (cnt_err_s[g])
        );
    end

    // Hazard reduction and sticky error next state.
    always_comb begin
        hazard = (|(hit_a_s & busy_s)) | (|(hit_b_s & busy_s));
        err_d  = err_q | (|cnt_err_s);
    end

    // Register array, sticky error and debug read-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == SP_IDX) begin
                    regs_q[r] <= DATA_W'(SP_INIT);
                end else begin
                    regs_q[r] <= '0;
                end
            end
            err_q     <= 1'b0;
            dbg_val_q <= '0;
        end else begin
            regs_q    <= regs_d;
            err_q     <= err_d;
            dbg_val_q <= dbg_val_d;
        end
    end

    assign err     = err_q;
    assign dbg_val = dbg_val_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed vector table for the documented scenarios, a short hand sequence
// for scoreboard underflow, then randomized traffic checked against an
// array-based reference model of the register file and scoreboard.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam logic [63:0] NEG90 = 64'hFFFF_FFFF_FFFF_FFA6;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM, issue_dstE, issue_dstM, dbg_sel;
    logic [63:0] valA, valB, valE, valM, dbg_val;
    logic        issue_valid, flush, hazard, err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W (64), .NREGS (15), .RIDX_W (4),
        .SP_IDX (4), .SP_INIT (256), .PEND_W (2)
    ) dut (
        .clk (clk), .rst (rst),
        .srcA (srcA), .srcB (srcB), .valA (valA), .valB (valB),
        .dstE (dstE), .dstM (dstM), .valE (valE), .valM (valM),
        .issue_valid (issue_valid), .issue_dstE (issue_dstE), .issue_dstM (issue_dstM),
        .flush (flush), .hazard (hazard), .err (err),
        .dbg_sel (dbg_sel), .dbg_val (dbg_val)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  srcA, srcB, dstE, dstM, idE, idM, dbg_sel;
        logic [63:0] valE, valM;
        logic        iv, flush;
        logic        chk;
        logic [63:0] e_valA, e_valB, e_dbg;
        logic        e_haz, e_err;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic [63:0] m_reg [16];
    int          m_cnt [16];
    logic        m_err;
    logic [63:0] m_dbg;

    function automatic vec_t idle();
        vec_t v;
        v.rst = 1'b0; v.srcA = 4'hF; v.srcB = 4'hF; v.dstE = 4'hF; v.dstM = 4'hF;
        v.idE = 4'hF; v.idM = 4'hF; v.dbg_sel = 4'hF; v.valE = 64'd0; v.valM = 64'd0;
        v.iv = 1'b0; v.flush = 1'b0; v.chk = 1'b1;
        v.e_valA = 64'd0; v.e_valB = 64'd0; v.e_dbg = 64'd0; v.e_haz = 1'b0; v.e_err = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; srcA = v.srcA; srcB = v.srcB; dstE = v.dstE; dstM = v.dstM;
        valE = v.valE; valM = v.valM; issue_valid = v.iv; issue_dstE = v.idE;
        issue_dstM = v.idM; flush = v.flush; dbg_sel = v.dbg_sel;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        #4;
        if (v.chk) begin
            check({tag, " valA"},    valA,           v.e_valA);
            check({tag, " valB"},    valB,           v.e_valB);
            check({tag, " hazard"},  64'(hazard),    64'(v.e_haz));
            check({tag, " err"},     64'(err),       64'(v.e_err));
            check({tag, " dbg_val"}, dbg_val,        v.e_dbg);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] m_read(input vec_t v, input logic [3:0] idx);
        if (idx >= 4'd15) return 64'd0;
        if (v.dstM == idx) return v.valM;
        if (v.dstE == idx) return v.valE;
        return m_reg[idx];
    endfunction

    function automatic logic m_haz(input vec_t v);
        logic h;
        h = 1'b0;
        if (v.srcA < 4'd15 && (m_cnt[v.srcA] - int'(v.dstE == v.srcA) - int'(v.dstM == v.srcA)) > 0) h = 1'b1;
        if (v.srcB < 4'd15 && (m_cnt[v.srcB] - int'(v.dstE == v.srcB) - int'(v.dstM == v.srcB)) > 0) h = 1'b1;
        return h;
    endfunction

    task automatic model_step(input vec_t v);
        if (v.rst) begin
            for (int r = 0; r < 16; r++) begin
                m_reg[r] = 64'd0;
                m_cnt[r] = 0;
            end
            m_reg[4] = 64'd256;
            m_err    = 1'b0;
            m_dbg    = 64'd0;
        end else begin
            if (v.dstE < 4'd15) m_reg[v.dstE] = v.valE;
            if (v.dstM < 4'd15) m_reg[v.dstM] = v.valM;
            for (int r = 0; r < 15; r++) begin
                int nx;
                if (v.flush) begin
                    nx = 0;
                end else begin
                    nx = m_cnt[r];
                    if (v.iv && v.idE == 4'(r)) nx++;
                    if (v.iv && v.idM == 4'(r)) nx++;
                    if (v.dstE == 4'(r)) nx--;
                    if (v.dstM == 4'(r)) nx--;
                    if (nx > 3) begin nx = 3; m_err = 1'b1; end
                    else if (nx < 0) begin nx = 0; m_err = 1'b1; end
                end
                m_cnt[r] = nx;
            end
            m_dbg = (v.dbg_sel < 4'd15) ? m_reg[v.dbg_sel] : 64'd0;
        end
    endtask

    function automatic logic [3:0] rnd_idx();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 8) return 4'hF;
        if (k == 9) return 4'd14;
        return 4'(k);
    endfunction

    initial begin
        vec_t v;
        drive(idle());
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- directed table ----------------
        v = idle(); v.rst = 1'b1; v.chk = 1'b0; tbl.push_back(v);
        v = idle(); v.srcA = 4'd4; v.srcB = 4'd0; v.dbg_sel = 4'd4; v.e_valA = 64'd256; tbl.push_back(v);
        v = idle(); v.srcB = 4'd1; v.dbg_sel = 4'd0; v.e_dbg = 64'd256; tbl.push_back(v);
        v = idle(); v.srcA = 4'd14; v.srcB = 4'd3; v.iv = 1'b1; v.idE = 4'd2; tbl.push_back(v);
        v = idle(); v.dstE = 4'd2; v.valE = NEG90; v.srcA = 4'd2; v.srcB = 4'd2; v.dbg_sel = 4'd2; v.e_valA = NEG90; v.e_valB = NEG90; tbl.push_back(v);
        v = idle(); v.srcA = 4'd2; v.e_valA = NEG90; v.e_dbg = NEG90; tbl.push_back(v);
        v = idle(); v.iv = 1'b1; v.idE = 4'd4; v.idM = 4'd4; v.srcA = 4'd4; v.e_valA = 64'd256; tbl.push_back(v);
        v = idle(); v.dstE = 4'd4; v.valE = 64'd24; v.dstM = 4'd4; v.valM = 64'd7; v.srcA = 4'd4; v.dbg_sel = 4'd4; v.e_valA = 64'd7; tbl.push_back(v);
        v = idle(); v.srcA = 4'd4; v.e_valA = 64'd7; v.e_dbg = 64'd7; tbl.push_back(v);
        v = idle(); v.iv = 1'b1; v.idM = 4'd3; v.srcA = 4'd3; tbl.push_back(v);
        v = idle(); v.srcA = 4'd3; v.e_haz = 1'b1; tbl.push_back(v);
        v = idle(); v.srcA = 4'd3; v.e_haz = 1'b1; tbl.push_back(v);
        v = idle(); v.dstM = 4'd3; v.valM = 64'h1234; v.srcA = 4'd3; v.dbg_sel = 4'd3; v.e_valA = 64'h1234; tbl.push_back(v);
        v = idle(); v.srcA = 4'd3; v.e_valA = 64'h1234; v.e_dbg = 64'h1234; tbl.push_back(v);
        for (int k = 0; k < 4; k++) begin
            v = idle(); v.iv = 1'b1; v.idE = 4'd5; v.srcB = 4'd5; v.e_haz = (k > 0); tbl.push_back(v);
        end
        v = idle(); v.srcB = 4'd5; v.e_haz = 1'b1; v.e_err = 1'b1; tbl.push_back(v);
        v = idle(); v.dstE = 4'd5; v.valE = 64'd1; v.srcB = 4'd5; v.dbg_sel = 4'd5; v.e_valB = 64'd1; v.e_haz = 1'b1; v.e_err = 1'b1; tbl.push_back(v);
        v = idle(); v.dstE = 4'd5; v.valE = 64'd2; v.srcB = 4'd5; v.e_valB = 64'd2; v.e_haz = 1'b1; v.e_err = 1'b1; v.e_dbg = 64'd1; tbl.push_back(v);
        v = idle(); v.srcB = 4'd5; v.e_valB = 64'd2; v.e_haz = 1'b1; v.e_err = 1'b1; tbl.push_back(v);
        v = idle(); v.iv = 1'b1; v.idE = 4'd5; v.flush = 1'b1; v.srcB = 4'd5; v.e_valB = 64'd2; v.e_haz = 1'b1; v.e_err = 1'b1; tbl.push_back(v);
        v = idle(); v.srcB = 4'd5; v.e_valB = 64'd2; v.e_err = 1'b1; tbl.push_back(v);
        v = idle(); v.rst = 1'b1; v.dstE = 4'd1; v.valE = 64'hAAAA; v.iv = 1'b1; v.idM = 4'd6; v.srcA = 4'd1; v.dbg_sel = 4'd1; v.e_valA = 64'hAAAA; v.e_err = 1'b1; tbl.push_back(v);
        v = idle(); v.srcA = 4'd1; v.srcB = 4'd6; tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // ---------------- hand sequence: retire with nothing pending ----------------
        v = idle(); v.dstM = 4'd7; v.valM = 64'd5; v.srcA = 4'd7; v.e_valA = 64'd5; run_vec("uflow0", v);
        v = idle(); v.srcA = 4'd7; v.e_valA = 64'd5; v.e_err = 1'b1; run_vec("uflow1", v);
        v = idle(); v.srcA = 4'd7; v.e_valA = 64'd5; v.e_err = 1'b1; run_vec("uflow2", v);

        // ---------------- randomized traffic vs. reference model ----------------
        for (int i = 0; i < 400; i++) begin
            v = idle();
            v.rst     = (i == 0) || ($urandom_range(0, 59) == 0);
            v.srcA    = rnd_idx();
            v.srcB    = rnd_idx();
            v.dstE    = rnd_idx();
            v.dstM    = rnd_idx();
            v.valE    = {$urandom, $urandom};
            v.valM    = {$urandom, $urandom};
            v.iv      = 1'($urandom_range(0, 1));
            v.idE     = rnd_idx();
            v.idM     = rnd_idx();
            v.flush   = ($urandom_range(0, 11) == 0);
            v.dbg_sel = rnd_idx();
            drive(v);
            #4;
            if (i > 0) begin
                check($sformatf("rnd%0d valA", i),    valA,         m_read(v, v.srcA));
                check($sformatf("rnd%0d valB", i),    valB,         m_read(v, v.srcB));
                check($sformatf("rnd%0d hazard", i),  64'(hazard),  64'(m_haz(v)));
                check($sformatf("rnd%0d err", i),     64'(err),     64'(m_err));
                check($sformatf("rnd%0d dbg_val", i), dbg_val,      m_dbg);
            end
            model_step(v);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
